// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module ex_muldiv_seq #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_REG_SIZE = 5,
  parameter int FUNCT3_SIZE    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [FUNCT3_SIZE-1:0]    funct3_i,
  input  logic [WD_SIZE-1:0]        op1_data_i,
  input  logic [WD_SIZE-1:0]        op2_data_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [WD_SIZE-1:0]        result_o,
  output logic [INSTR_REG_SIZE-1:0] rd_o
);

  localparam int CW = $clog2(WD_SIZE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = FUNCT3_SIZE'(0);
  localparam logic [FUNCT3_SIZE-1:0] F3_MULH   = FUNCT3_SIZE'(1);
  localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = FUNCT3_SIZE'(2);
  localparam logic [FUNCT3_SIZE-1:0] F3_DIV    = FUNCT3_SIZE'(4);
  localparam logic [FUNCT3_SIZE-1:0] F3_REM    = FUNCT3_SIZE'(6);

  localparam logic [WD_SIZE-1:0] MIN_NEG = {1'b1, {(WD_SIZE-1){1'b0}}};

  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [FUNCT3_SIZE-1:0] f3_q;
  logic                   neg_q;    // result must be negated at the end
  logic [WD_SIZE-1:0]     opb_q;    // multiplicand (mul) or divisor (div)
  logic [WD_SIZE-1:0]     acc_hi;   // product high / partial remainder
  logic [WD_SIZE-1:0]     acc_lo;   // multiplier bits / dividend->quotient

  assign req_ready_o  = (state == ST_IDLE) && !reset;
  assign busy_o       = (state != ST_IDLE) || (req_valid_i && req_ready_o);
  assign resp_valid_o = (state == ST_DONE);

  // Operand decode at accept: MUL is run unsigned since its low half is
  // sign-independent, which keeps the final correction to high-half ops.
  logic               sgn1, sgn2, neg1, neg2, res_neg, div0, ovf, fast;
  logic [WD_SIZE-1:0] mag1, mag2, fast_res;

  always_comb begin
    sgn1     = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
               (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    sgn2     = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    neg1     = sgn1 && op1_data_i[WD_SIZE-1];
    neg2     = sgn2 && op2_data_i[WD_SIZE-1];
    mag1     = neg1 ? -op1_data_i : op1_data_i;
    mag2     = neg2 ? -op2_data_i : op2_data_i;
    res_neg  = (funct3_i == F3_REM) ? neg1 : (neg1 ^ neg2);
    div0     = funct3_i[2] && (op2_data_i == '0);
    ovf      = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
               (op1_data_i == MIN_NEG) && (op2_data_i == '1);
    fast     = div0 || ovf;
    fast_res = '0;
    if (div0)     fast_res = funct3_i[1] ? op1_data_i : '1;
    else if (ovf) fast_res = funct3_i[1] ? '0 : MIN_NEG;
  end

  // One iteration of both datapaths plus the sign-corrected final result.
  logic [WD_SIZE:0]       mul_sum, div_sh, div_diff;
  logic                   div_ok;
  logic [WD_SIZE-1:0]     hi_nx, lo_nx, quo_s, rem_s, final_res;
  logic [2*WD_SIZE-1:0]   prod, prod_s;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_hi, acc_lo[WD_SIZE-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ok   = !div_diff[WD_SIZE];
    if (f3_q[2]) begin
      hi_nx = div_ok ? div_diff[WD_SIZE-1:0] : div_sh[WD_SIZE-1:0];
      lo_nx = {acc_lo[WD_SIZE-2:0], div_ok};
    end else begin
      hi_nx = mul_sum[WD_SIZE:1];
      lo_nx = {mul_sum[0], acc_lo[WD_SIZE-1:1]};
    end
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nx : lo_nx;
    rem_s  = neg_q ? -hi_nx : hi_nx;
    if (f3_q[2])             final_res = f3_q[1] ? rem_s : quo_s;
    else if (f3_q == F3_MUL) final_res = prod_s[WD_SIZE-1:0];
    else                     final_res = prod_s[2*WD_SIZE-1:WD_SIZE];
  end

  // Sequencer: accept, iterate, hold result until writeback takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (req_valid_i) begin
          f3_q  <= funct3_i;
          rd_o  <= rd_i;
          neg_q <= res_neg;
          if (fast) begin
            result_o <= fast_res;
            state    <= ST_DONE;
          end else begin
            opb_q  <= funct3_i[2] ? mag2 : mag1;
            acc_lo <= funct3_i[2] ? mag1 : mag2;
            acc_hi <= '0;
            cnt    <= CW'(WD_SIZE-1);
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            result_o <= final_res;
            state    <= ST_DONE;
          end
        end
        ST_DONE: if (resp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
